ebpc_stream_splitter: RTL and testbench

Upstream neighbour of ebpc_decoder. Takes one serial byte stream of compressed frames and splits it into the decoder's three inputs: num_words, bpc bytes and znz bytes.

---
 rtl/ebpc_pkg.sv | 19 +
 rtl/ebpc_stream_splitter.sv | 179 +++++++++++++++++
 tb/tb_ebpc_stream_splitter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ebpc_pkg.sv
// Shared constants and types for the EBPC stream path (splitter and decoder).
package ebpc_pkg;

  localparam int LOG_MAX_WORDS   = 12;
  localparam int NUM_WORDS_BYTES = (LOG_MAX_WORDS + 7) / 8;

  typedef enum logic [1:0] {
    HDR,
    TAG,
    PAYLOAD
  } split_state_t;

  localparam logic TAG_SEL_BPC = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ebpc_stream_splitter.sv
// Splits one compressed byte stream into num_words, bpc and znz streams.
// Optional per-frame statistics outputs when EBPC_SPLIT_STATS_EN is defined.
module ebpc_stream_splitter
  import ebpc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NW_BYTES = NUM_WORDS_BYTES
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_W-1:0]        in_i,
  input  logic                     in_last_i,
  input  logic                     in_vld_i,
  output logic                     in_rdy_o,
  output logic [LOG_MAX_WORDS-1:0] num_words_o,
  output logic                     num_words_vld_o,
  input  logic                     num_words_rdy_i,
  output logic [DATA_W-1:0]        bpc_o,
  output logic                     bpc_vld_o,
  input  logic                     bpc_rdy_i,
  output logic [DATA_W-1:0]        znz_o,
  output logic                     znz_vld_o,
  input  logic                     znz_rdy_i,
`ifdef EBPC_SPLIT_STATS_EN
  output logic [15:0]              stat_znz_bytes_o,
  output logic [15:0]              stat_bpc_bytes_o,
  output logic [15:0]              stat_frames_o,
`endif
  output logic                     err_o
);

  localparam int CNT_W = $clog2(NW_BYTES + 1);
  localparam int REM_W = DATA_W - 1;

  if (DATA_W != 8) begin : g_bad_width
    $error("ebpc_stream_splitter: only DATA_W = 8 is supported");
  end

  split_state_t             state_reg;
  logic [CNT_W-1:0]         hdr_cnt_reg;
  logic [REM_W-1:0]         rem_reg;
  logic                     sel_reg;
  logic [LOG_MAX_WORDS-1:0] nw_reg;
  logic                     nw_vld_reg;
  logic                     err_reg;
  logic                     run_reg;
  logic                     in_fire;

  // Payload bytes bypass any register so chunks stream at full rate.
  always_comb begin
    in_rdy_o  = 1'b0;
    bpc_vld_o = 1'b0;
    znz_vld_o = 1'b0;
    case (state_reg)
      HDR:     in_rdy_o = run_reg && !nw_vld_reg;
      TAG:     in_rdy_o = 1'b1;
      PAYLOAD: begin
        in_rdy_o  = (sel_reg == TAG_SEL_BPC) ? bpc_rdy_i : znz_rdy_i;
        bpc_vld_o = (sel_reg == TAG_SEL_BPC) && in_vld_i;
        znz_vld_o = (sel_reg != TAG_SEL_BPC) && in_vld_i;
      end
      default: in_rdy_o = 1'b0;
    endcase
  end

  assign in_fire         = in_vld_i && in_rdy_o;
  assign bpc_o           = in_i;
  assign znz_o           = in_i;
  assign num_words_o     = nw_reg;
  assign num_words_vld_o = nw_vld_reg;
  assign err_o           = err_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= HDR;
      hdr_cnt_reg <= '0;
      rem_reg     <= '0;
      sel_reg     <= 1'b0;
      nw_reg      <= '0;
      nw_vld_reg  <= 1'b0;
      err_reg     <= 1'b0;
      run_reg     <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (nw_vld_reg && num_words_rdy_i) begin
        nw_vld_reg <= 1'b0;
      end
      if (in_fire) begin
        case (state_reg)
          HDR: begin
            // Little-endian header; bits beyond LOG_MAX_WORDS are dropped.
            for (int k = 0; k < LOG_MAX_WORDS; k++) begin
              if (hdr_cnt_reg == CNT_W'(k / 8)) begin
                nw_reg[k] <= in_i[k % 8];
              end
            end
            if (in_last_i) begin
              err_reg     <= 1'b1;
              hdr_cnt_reg <= '0;
            end else if (hdr_cnt_reg == CNT_W'(NW_BYTES - 1)) begin
              hdr_cnt_reg <= '0;
              nw_vld_reg  <= 1'b1;
              state_reg   <= TAG;
            end else begin
              hdr_cnt_reg <= hdr_cnt_reg + CNT_W'(1);
            end
          end
          TAG: begin
            if (in_last_i) begin
              err_reg   <= 1'b1;
              state_reg <= HDR;
            end else begin
              sel_reg   <= in_i[DATA_W-1];
              rem_reg   <= in_i[DATA_W-2:0];
              state_reg <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            rem_reg <= rem_reg - REM_W'(1);
            if (rem_reg == '0) begin
              state_reg <= in_last_i ? HDR : TAG;
            end else if (in_last_i) begin
              err_reg   <= 1'b1;
              state_reg <= HDR;
            end
          end
          default: state_reg <= HDR;
        endcase
      end
    end
  end

`ifdef EBPC_SPLIT_STATS_EN
  logic [15:0] znz_acc_reg, bpc_acc_reg;
  logic [15:0] znz_acc_next, bpc_acc_next;
  logic [15:0] znz_stat_reg, bpc_stat_reg, frames_reg;
  logic        pay_fire, frame_end, frame_abort;

  assign pay_fire    = in_fire && (state_reg == PAYLOAD);
  assign frame_end   = pay_fire && (rem_reg == '0) && in_last_i;
  assign frame_abort = in_fire && in_last_i && !frame_end;

  always_comb begin
    znz_acc_next = znz_acc_reg;
    bpc_acc_next = bpc_acc_reg;
    if (pay_fire) begin
      if (sel_reg == TAG_SEL_BPC) bpc_acc_next = sat_inc16(bpc_acc_reg);
      else                        znz_acc_next = sat_inc16(znz_acc_reg);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      znz_acc_reg  <= '0;
      bpc_acc_reg  <= '0;
      znz_stat_reg <= '0;
      bpc_stat_reg <= '0;
      frames_reg   <= '0;
    end else if (frame_end) begin
      znz_stat_reg <= znz_acc_next;
      bpc_stat_reg <= bpc_acc_next;
      frames_reg   <= frames_reg + 16'd1;
      znz_acc_reg  <= '0;
      bpc_acc_reg  <= '0;
    end else if (frame_abort) begin
      znz_acc_reg <= '0;
      bpc_acc_reg <= '0;
    end else begin
      znz_acc_reg <= znz_acc_next;
      bpc_acc_reg <= bpc_acc_next;
    end
  end

  assign stat_znz_bytes_o = znz_stat_reg;
  assign stat_bpc_bytes_o = bpc_stat_reg;
  assign stat_frames_o    = frames_reg;
`endif

endmodule

// File: tb/tb_ebpc_stream_splitter.sv
// Directed bench for ebpc_stream_splitter: frames, backpressure, errors, reset.
module tb_ebpc_stream_splitter;
  import ebpc_pkg::*;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [7:0]               in_i = '0;
  logic                     in_last_i = 1'b0;
  logic                     in_vld_i = 1'b0;
  logic                     in_rdy_o;
  logic [LOG_MAX_WORDS-1:0] num_words_o;
  logic                     num_words_vld_o;
  logic                     num_words_rdy_i = 1'b1;
  logic [7:0]               bpc_o;
  logic                     bpc_vld_o;
  logic                     bpc_rdy_i = 1'b1;
  logic [7:0]               znz_o;
  logic                     znz_vld_o;
  logic                     znz_rdy_i = 1'b1;
  logic                     err_o;
`ifdef EBPC_SPLIT_STATS_EN
  logic [15:0] stat_znz, stat_bpc, stat_frames;
`endif

  ebpc_stream_splitter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_i(in_i), .in_last_i(in_last_i), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o),
    .num_words_o(num_words_o), .num_words_vld_o(num_words_vld_o),
    .num_words_rdy_i(num_words_rdy_i),
    .bpc_o(bpc_o), .bpc_vld_o(bpc_vld_o), .bpc_rdy_i(bpc_rdy_i),
    .znz_o(znz_o), .znz_vld_o(znz_vld_o), .znz_rdy_i(znz_rdy_i),
`ifdef EBPC_SPLIT_STATS_EN
    .stat_znz_bytes_o(stat_znz), .stat_bpc_bytes_o(stat_bpc), .stat_frames_o(stat_frames),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Ready sources: either forced levels or random stalls.
  logic rand_mode = 1'b0;
  logic bpc_force = 1'b1, znz_force = 1'b1, nw_force = 1'b1;
  always @(posedge clk_i) begin
    #1;
    bpc_rdy_i       = rand_mode ? ($urandom_range(0, 3) != 0) : bpc_force;
    znz_rdy_i       = rand_mode ? ($urandom_range(0, 3) != 0) : znz_force;
    num_words_rdy_i = rand_mode ? ($urandom_range(0, 3) != 0) : nw_force;
  end

  // Transfers are recorded in the stable window before the next rising edge.
  logic [7:0]               bpc_q[$];
  logic [7:0]               znz_q[$];
  logic [LOG_MAX_WORDS-1:0] nw_q[$];
  always @(negedge clk_i) begin
    #2;
    if (bpc_vld_o && bpc_rdy_i) bpc_q.push_back(bpc_o);
    if (znz_vld_o && znz_rdy_i) znz_q.push_back(znz_o);
    if (num_words_vld_o && num_words_rdy_i) nw_q.push_back(num_words_o);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, ".len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after the byte is taken.
  task automatic send(input logic [7:0] b, input logic last, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    in_i = b; in_last_i = last; in_vld_i = 1'b1;
    while (!acc && waits < 200) begin
      #1;
      acc = in_rdy_o;
      @(negedge clk_i);
      if (!acc) waits++;
    end
    if (!acc) begin
      bad++;
      $error("FAIL send_timeout: observed=no_accept expected=accept byte=%0h", b);
    end
    in_vld_i = 1'b0; in_last_i = 1'b0;
  endtask

  task automatic sb(input logic [7:0] b, input logic last = 1'b0);
    int w;
    send(b, last, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_q();
    bpc_q.delete(); znz_q.delete(); nw_q.delete();
  endtask

  task automatic basic_frame();
    sb(8'h40); sb(8'h00);
    sb(8'h02); sb(8'h11); sb(8'h22); sb(8'h33);
    sb(8'h81); sb(8'h44); sb(8'h55, 1'b1);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int w;

    // Reset state
    #1;
    chk("rst.in_rdy", in_rdy_o, 0);
    chk("rst.bpc_vld", bpc_vld_o, 0);
    chk("rst.znz_vld", znz_vld_o, 0);
    chk("rst.nw_vld", num_words_vld_o, 0);
    chk("rst.err", err_o, 0);
    chk("rst.num_words", num_words_o, 0);
    idle(2);
    rst_ni = 1'b1;
    idle(1);

    // Basic frame
    clear_q();
    basic_frame();
    idle(4);
    chk("basic.nw.len", nw_q.size(), 1);
    if (nw_q.size() > 0) chk("basic.nw", nw_q[0], 12'h040);
    exp_q = {8'h11, 8'h22, 8'h33}; chk_q("basic.znz", znz_q, exp_q);
    exp_q = {8'h44, 8'h55};        chk_q("basic.bpc", bpc_q, exp_q);
    chk("basic.err", err_o, 0);

    // Same frame under random stalls
    clear_q();
    rand_mode = 1'b1;
    basic_frame();
    idle(20);
    rand_mode = 1'b0;
    idle(2);
    chk("bp.nw.len", nw_q.size(), 1);
    if (nw_q.size() > 0) chk("bp.nw", nw_q[0], 12'h040);
    exp_q = {8'h11, 8'h22, 8'h33}; chk_q("bp.znz", znz_q, exp_q);
    exp_q = {8'h44, 8'h55};        chk_q("bp.bpc", bpc_q, exp_q);
    chk("bp.err", err_o, 0);

    // Back-to-back with num_words held off; header upper bits ignored
    clear_q();
    nw_force = 1'b0;
    idle(1);
    sb(8'h34); sb(8'h12);
    sb(8'h80); sb(8'h66);
    sb(8'h00); sb(8'h77, 1'b1);
    in_i = 8'h05; in_vld_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("b2b.stall%0d", i), in_rdy_o, 0);
      @(negedge clk_i);
    end
    chk("b2b.nw_vld", num_words_vld_o, 1);
    chk("b2b.num_words", num_words_o, 12'h234);
    nw_force = 1'b1;
    sb(8'h05); sb(8'h00);
    sb(8'h01); sb(8'h88); sb(8'h99, 1'b1);
    send(8'h03, 1'b0, w);
    chk("b2b.next_hdr_waits", w, 0);
    sb(8'h00); sb(8'h00); sb(8'hAB, 1'b1);
    idle(4);
    chk("b2b.nw.len", nw_q.size(), 3);
    if (nw_q.size() == 3) begin
      chk("b2b.nw0", nw_q[0], 12'h234);
      chk("b2b.nw1", nw_q[1], 12'h005);
      chk("b2b.nw2", nw_q[2], 12'h003);
    end
    exp_q = {8'h66};                      chk_q("b2b.bpc", bpc_q, exp_q);
    exp_q = {8'h77, 8'h88, 8'h99, 8'hAB}; chk_q("b2b.znz", znz_q, exp_q);

    // Max then min chunk
    clear_q();
    sb(8'h80); sb(8'h00);
    sb(8'hFF);
    exp_q = {};
    for (int i = 0; i < 128; i++) begin
      sb(8'(i));
      exp_q.push_back(8'(i));
    end
    sb(8'h00); sb(8'hEE, 1'b1);
    idle(3);
    chk_q("max.bpc", bpc_q, exp_q);
    exp_q = {8'hEE}; chk_q("min.znz", znz_q, exp_q);
    chk("maxmin.err", err_o, 0);

    // Truncated chunk, then recovery
    clear_q();
    sb(8'h01); sb(8'h00);
    sb(8'h04); sb(8'h10); sb(8'h20, 1'b1);
    idle(1);
    chk("err.set", err_o, 1);
    sb(8'h02); sb(8'h00);
    sb(8'h80); sb(8'h5A, 1'b1);
    idle(3);
    chk("err.sticky", err_o, 1);
    exp_q = {8'h10, 8'h20}; chk_q("err.znz", znz_q, exp_q);
    exp_q = {8'h5A};        chk_q("err.bpc", bpc_q, exp_q);
    chk("err.nw.len", nw_q.size(), 2);
    if (nw_q.size() == 2) chk("err.nw1", nw_q[1], 12'h002);

    // Async reset in the middle of a payload
    sb(8'h09); sb(8'h00);
    sb(8'h83); sb(8'h01); sb(8'h02);
    in_i = 8'h03; in_vld_i = 1'b1;
    #1;
    chk("rstmid.bpc_vld_pre", bpc_vld_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rstmid.bpc_vld", bpc_vld_o, 0);
    chk("rstmid.znz_vld", znz_vld_o, 0);
    chk("rstmid.in_rdy", in_rdy_o, 0);
    chk("rstmid.nw_vld", num_words_vld_o, 0);
    chk("rstmid.err", err_o, 0);
    in_vld_i = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    clear_q();
    sb(8'h07); sb(8'h00);
    sb(8'h01); sb(8'hC1); sb(8'hC2, 1'b1);
    idle(3);
    exp_q = {8'hC1, 8'hC2}; chk_q("rstmid.znz", znz_q, exp_q);
    chk("rstmid.bpc.len", bpc_q.size(), 0);
    chk("rstmid.nw.len", nw_q.size(), 1);
    if (nw_q.size() > 0) chk("rstmid.nw", nw_q[0], 12'h007);
    chk("rstmid.err_after", err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $fatal(1, "FAIL global_timeout: observed=running expected=finished");
  end

endmodule
